limc_scan_ctrl: RTL and testbench
=================================

// Module: limc_scan_ctrl
// PURPOSE
//   On-chip scan-test controller that drives the scan interface of the LIMC block:
//   generates scan_in[4:0], scan_enable and test_mode, and compacts the returning
//   scan_out[4:0] into a 32-bit MISR signature. Pattern source is an internal LFSR.
//   Sits beside LIMC as the driving end of its scan chains (BIST-style self test).
// PARAMETERS
//   CHAIN_LEN  32            flops per scan chain (all 5 chains equal length), >=2
//   PATTERNS   16            number of patterns loaded/captured per run, >=1
//   SEED       32'h1        LFSR seed, must be nonzero
//   POLY       32'h00400007  feedback taps for LFSR and MISR (x^32+x^22+x^2+x+1)
// PORTS
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   start        in   1   begin a test run (sampled only in IDLE)
//   scan_out     in   5   chain outputs from LIMC scan_out0..scan_out4 (bit i = chain i)
//   scan_in      out  5   chain inputs to LIMC scan_in0..scan_in4 (bit i = chain i)
//   scan_enable  out  1   1 = shift, 0 = functional capture
//   test_mode    out  1   held high for the whole run
//   busy         out  1   high from the cycle after start is accepted until DONE
//   done         out  1   one-cycle pulse at end of run
//   signature    out  32  MISR result; valid when done=1, held until next start
// BEHAVIOUR
// - All outputs registered. Reset: state=IDLE; scan_in=0, scan_enable=0, test_mode=0,
//   busy=0, done=0, signature=0, LFSR=SEED, counters=0. Reset mid-run aborts at once.
// - FSM: IDLE -> SHIFT -> CAPTURE -> SHIFT ... -> FLUSH -> DONE -> IDLE.
//   IDLE:    start=1 -> SHIFT; LFSR<=SEED, signature<=0, pat_cnt<=0, bit_cnt<=0.
//   SHIFT:   CHAIN_LEN cycles, scan_enable=1, scan_in=lfsr[4:0], LFSR advances once
//            per cycle. bit_cnt==CHAIN_LEN-1 -> CAPTURE.
//   CAPTURE: 1 cycle, scan_enable=0, scan_in=0, LFSR frozen; pat_cnt++;
//            pat_cnt==PATTERNS-1 (before increment) -> FLUSH, else -> SHIFT.
//   FLUSH:   CHAIN_LEN cycles, scan_enable=1, scan_in=0 (unloads last capture).
//   DONE:    1 cycle, done=1, busy=0, scan_enable=0, test_mode=0 -> IDLE.
// - test_mode=1 and busy=1 in SHIFT, CAPTURE, FLUSH; 0 in IDLE and DONE.
// - Run length: busy high for (PATTERNS+1)*CHAIN_LEN + PATTERNS cycles.
// - LFSR step (Galois, left shift): l <= {l[30:0],1'b0} ^ (l[31] ? POLY : 0).
// - MISR step: s <= {s[30:0],1'b0} ^ (s[31] ? POLY : 0) ^ {27'b0, scan_out}.
//   MISR updates every SHIFT cycle except the first shift phase (pat_cnt==0, chains
//   hold pre-test state) and every FLUSH cycle; scan_out sampled in same cycle it is
//   presented. MISR frozen in IDLE, CAPTURE, DONE.
// - start while busy or in DONE: ignored. start held high across DONE: new run
//   begins from IDLE on the following cycle (no back-to-back from DONE).
// - Counters sized $clog2(CHAIN_LEN) and $clog2(PATTERNS+1); no wrap in valid use.
// TESTING
// 1 CHAIN_LEN=4,PATTERNS=2, scan_out=0, start pulse -> busy high exactly 14 cycles,
//   scan_enable pattern 1111 0 1111 0 1111, one done pulse, signature=32'h0.
// 2 CHAIN_LEN=4,PATTERNS=1, scan_out=5'b00001 constant -> MISR absorbs only the
//   4 FLUSH cycles, signature=32'h0000000F; PATTERNS=2 -> 32'h000000FF.
// 3 SEED=1: first SHIFT drives scan_in = 5'h01,5'h02,5'h04,5'h08 on cycles 1..4
//   after start; CAPTURE cycle shows scan_in=0, scan_enable=0, test_mode=1.
// 4 Loopback model: 5 chains of CHAIN_LEN flops with capture = bitwise invert,
//   PATTERNS=16, CHAIN_LEN=32 -> signature equals SV reference-model value.
// 5 reset asserted mid SHIFT of pattern 3 -> next cycle all outputs 0, state IDLE;
//   new start reproduces the same signature as an uninterrupted run.
// 6 start pulsed during SHIFT and during DONE -> ignored, run length and signature
//   unchanged; start held high -> second run begins 1 cycle after DONE.

Source files
------------

// File: rtl/limc_scan_ctrl.sv
// limc_scan_ctrl: BIST-style scan controller for the LIMC block.
// Ports: clk, reset (sync, active-high), start; scan_out[4:0] in from chains;
//   scan_in[4:0], scan_enable, test_mode, busy, done, signature[31:0] out.
//   An internal LFSR sources patterns; a MISR compacts scan_out.
module limc_scan_ctrl #(
    parameter int          CHAIN_LEN = 32,
    parameter int          PATTERNS  = 16,
    parameter logic [31:0] SEED      = 32'h1,
    parameter logic [31:0] POLY      = 32'h0040_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  scan_out,
    output logic [4:0]  scan_in,
    output logic        scan_enable,
    output logic        test_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] signature
);

    localparam int BW = $clog2(CHAIN_LEN);
    localparam int PW = $clog2(PATTERNS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST = PW'(PATTERNS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

    state_t          state;
    logic [31:0]     lfsr;
    logic [BW-1:0]   bit_cnt;
    logic [PW-1:0]   pat_cnt;
    logic [31:0]     lfsr_nx;
    logic [31:0]     misr_nx;

    always_comb begin
        lfsr_nx = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? POLY : 32'h0);
        misr_nx = {signature[30:0], 1'b0}
                ^ (signature[31] ? POLY : 32'h0)
                ^ {27'b0, scan_out};
    end

    // scan_in is registered alongside lfsr so that, while in SHIFT,
    // scan_in always equals the low bits of the current lfsr value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= SEED;
            bit_cnt     <= '0;
            pat_cnt     <= '0;
            scan_in     <= '0;
            scan_enable <= 1'b0;
            test_mode   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            signature   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SHIFT;
                        lfsr        <= SEED;
                        signature   <= '0;
                        pat_cnt     <= '0;
                        bit_cnt     <= '0;
                        scan_in     <= SEED[4:0];
                        scan_enable <= 1'b1;
                        test_mode   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    lfsr <= lfsr_nx;
                    // First load only pushes out pre-test chain contents.
                    if (pat_cnt != '0)
                        signature <= misr_nx;
                    if (bit_cnt == BIT_LAST) begin
                        state       <= CAPTURE;
                        bit_cnt     <= '0;
                        scan_in     <= '0;
                        scan_enable <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        scan_in <= lfsr_nx[4:0];
                    end
                end
                CAPTURE: begin
                    pat_cnt     <= pat_cnt + 1'b1;
                    scan_enable <= 1'b1;
                    if (pat_cnt == PAT_LAST) begin
                        state   <= FLUSH;
                        scan_in <= '0;
                    end else begin
                        state   <= SHIFT;
                        scan_in <= lfsr[4:0];
                    end
                end
                FLUSH: begin
                    signature <= misr_nx;
                    if (bit_cnt == BIT_LAST) begin
                        state       <= DONE;
                        bit_cnt     <= '0;
                        scan_enable <= 1'b0;
                        test_mode   <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_limc_scan_ctrl.sv
// tb_limc_scan_ctrl: self-checking bench for limc_scan_ctrl.
// Three instances: (4,2) and (4,1) driven directly, (32,16) with chain loopback.
module tb_limc_scan_ctrl;

    localparam logic [31:0] SEED = 32'h1;
    localparam logic [31:0] POLY = 32'h0040_0007;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v [3];
    logic [4:0]  so_drv [2];
    wire  [4:0]  so_in [3];
    wire  [4:0]  si_v [3];
    wire         se_v [3];
    wire         tm_v [3];
    wire         busy_v [3];
    wire         done_v [3];
    wire  [31:0] sig_v [3];
    logic [4:0]  so_c;
    logic [31:0] ch [5];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign so_in[0] = so_drv[0];
    assign so_in[1] = so_drv[1];
    assign so_in[2] = so_c;

    limc_scan_ctrl #(.CHAIN_LEN(4), .PATTERNS(2), .SEED(SEED), .POLY(POLY)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .scan_out(so_in[0]),
        .scan_in(si_v[0]), .scan_enable(se_v[0]), .test_mode(tm_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .signature(sig_v[0]));

    limc_scan_ctrl #(.CHAIN_LEN(4), .PATTERNS(1), .SEED(SEED), .POLY(POLY)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .scan_out(so_in[1]),
        .scan_in(si_v[1]), .scan_enable(se_v[1]), .test_mode(tm_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .signature(sig_v[1]));

    limc_scan_ctrl #(.CHAIN_LEN(32), .PATTERNS(16), .SEED(SEED), .POLY(POLY)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .scan_out(so_in[2]),
        .scan_in(si_v[2]), .scan_enable(se_v[2]), .test_mode(tm_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .signature(sig_v[2]));

    // Five 32-flop chains behind dut_c; capture inverts every flop.
    always_comb begin
        so_c = '0;
        for (int i = 0; i < 5; i++) so_c[i] = ch[i][31];
    end

    always @(posedge clk) begin
        if (se_v[2]) begin
            for (int i = 0; i < 5; i++) ch[i] <= {ch[i][30:0], si_v[2][i]};
        end else if (tm_v[2]) begin
            for (int i = 0; i < 5; i++) ch[i] <= ~ch[i];
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] lstep(input logic [31:0] l);
        return {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] mstep(input logic [31:0] s, input logic [4:0] so);
        return lstep(s) ^ {27'b0, so};
    endfunction

    function automatic logic [31:0] lfsr_n(input int n);
        logic [31:0] l = SEED;
        for (int k = 0; k < n; k++) l = lstep(l);
        return l;
    endfunction

    function automatic int len_of(input int w);
        return (w < 2) ? 4 : 32;
    endfunction

    function automatic int pat_of(input int w);
        return (w == 0) ? 2 : (w == 1) ? 1 : 16;
    endfunction

    // Expected {scan_enable, test_mode, scan_in} for busy cycle t.
    function automatic logic [6:0] exp_vec(input int L, input int P, input int t);
        int ph = t / (L + 1);
        int wi = t % (L + 1);
        logic [31:0] l;
        if (ph < P && wi < L) begin
            l = lfsr_n(ph * L + wi);
            return {2'b11, l[4:0]};
        end else if (ph < P) begin
            return 7'b01_00000;
        end
        return 7'b11_00000;
    endfunction

    logic [4:0] q_so [$];
    logic [6:0] q_out [$];

    // Signature from recorded scan_out per busy cycle.
    function automatic logic [31:0] ref_q(input int L, input int P);
        logic [31:0] s = '0;
        for (int t = 0; t < q_so.size(); t++) begin
            int ph = t / (L + 1);
            int wi = t % (L + 1);
            if ((ph < P && wi < L && ph != 0) || ph == P) s = mstep(s, q_so[t]);
        end
        return s;
    endfunction

    // Signature of a full loopback run through invert-capture chains.
    function automatic logic [31:0] ref_loop(input int L, input int P);
        logic [31:0] c [5];
        logic [31:0] l = SEED;
        logic [31:0] s = '0;
        logic [4:0]  so;
        for (int i = 0; i < 5; i++) c[i] = '0;
        for (int p = 0; p < P; p++) begin
            for (int b = 0; b < L; b++) begin
                for (int i = 0; i < 5; i++) so[i] = c[i][L-1];
                if (p != 0) s = mstep(s, so);
                for (int i = 0; i < 5; i++) c[i] = {c[i][30:0], l[i]};
                l = lstep(l);
            end
            for (int i = 0; i < 5; i++) c[i] = ~c[i];
        end
        for (int b = 0; b < L; b++) begin
            for (int i = 0; i < 5; i++) so[i] = c[i][L-1];
            s = mstep(s, so);
            for (int i = 0; i < 5; i++) c[i] = {c[i][30:0], 1'b0};
        end
        return s;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [4:0]  so_const;
    int          blen;
    int          early_done;
    logic        r_done;
    logic [31:0] r_sig;

    task automatic run(input int w, input bit rnd, input bit mid, input bit hold);
        logic [4:0] so;
        q_so.delete();
        q_out.delete();
        blen = 0;
        early_done = 0;
        @(negedge clk);
        start_v[w] = 1'b1;
        @(negedge clk);
        if (!hold) start_v[w] = 1'b0;
        while (busy_v[w] && blen < 2000) begin
            q_out.push_back({se_v[w], tm_v[w], si_v[w]});
            if (done_v[w]) early_done++;
            so = rnd ? 5'($urandom) : so_const;
            if (w < 2) so_drv[w] = so;
            q_so.push_back(so);
            if (mid && blen == 2) start_v[w] = 1'b1;
            if (mid && blen == 3) start_v[w] = 1'b0;
            blen++;
            @(negedge clk);
        end
        if (blen >= 2000) chk("run_timeout", 32'(blen), 32'd0);
        r_done = done_v[w];
        r_sig = sig_v[w];
    endtask

    task automatic check_run(input int w, input logic [31:0] exp_sig);
        int L = len_of(w);
        int P = pat_of(w);
        int bad = 0;
        chk("busy_len", 32'(blen), 32'((P + 1) * L + P));
        chk("done_pulse", {31'b0, r_done}, 32'd1);
        chk("done_early", 32'(early_done), 32'd0);
        for (int t = 0; t < q_out.size(); t++)
            if (q_out[t] !== exp_vec(L, P, t)) bad++;
        chk("cycle_outputs", 32'(bad), 32'd0);
        chk("signature", r_sig, exp_sig);
        @(negedge clk);
        chk("done_clear", {31'b0, done_v[w]}, 32'd0);
        chk("busy_after", {31'b0, busy_v[w]}, 32'd0);
        chk("sig_held", sig_v[w], exp_sig);
    endtask

    typedef struct {
        int          w;
        logic [4:0]  so;
        logic [31:0] sig;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n;
        logic [14:0] se_bits;

        tbl[0] = '{0, 5'h00, 32'h0000_0000};
        tbl[1] = '{1, 5'h01, 32'h0000_000F};
        tbl[2] = '{0, 5'h01, 32'h0000_00FF};
        tbl[3] = '{1, 5'h1F, 32'h0000_00A5};
        tbl[4] = '{1, 5'h00, 32'h0000_0000};

        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        so_drv[0] = '0;
        so_drv[1] = '0;
        so_const = '0;
        for (int i = 0; i < 5; i++) ch[i] = $urandom;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("reset_state",
                {si_v[i], se_v[i], tm_v[i], busy_v[i], done_v[i], 22'b0} | sig_v[i],
                32'd0);
        reset = 1'b0;

        // Constant scan_out vectors.
        for (int i = 0; i < 5; i++) begin
            so_const = tbl[i].so;
            run(tbl[i].w, 1'b0, 1'b0, 1'b0);
            check_run(tbl[i].w, tbl[i].sig);
        end

        // Shift-enable shape and first pattern words.
        so_const = '0;
        run(0, 1'b0, 1'b0, 1'b0);
        se_bits = '0;
        for (int t = 0; t < q_out.size() && t < 15; t++) se_bits[14-t] = q_out[t][6];
        chk("se_shape", {17'b0, se_bits}, {17'b0, 15'b111101111011110});
        chk("si_c1", {27'b0, q_out[0][4:0]}, 32'h01);
        chk("si_c2", {27'b0, q_out[1][4:0]}, 32'h02);
        chk("si_c3", {27'b0, q_out[2][4:0]}, 32'h04);
        chk("si_c4", {27'b0, q_out[3][4:0]}, 32'h08);
        chk("capture_cyc", {25'b0, q_out[4]}, {25'b0, 7'b01_00000});
        check_run(0, 32'h0);

        // Randomized scan_out against the recorded-stream model.
        for (int k = 0; k < 6; k++) begin
            run(k % 2, 1'b1, 1'b0, 1'b0);
            check_run(k % 2, ref_q(len_of(k % 2), pat_of(k % 2)));
        end

        // Loopback run.
        run(2, 1'b0, 1'b0, 1'b0);
        check_run(2, ref_loop(32, 16));

        // Reset in the middle of the third pattern's shift.
        @(negedge clk);
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (70) @(negedge clk);
        chk("mid_busy", {31'b0, busy_v[2]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset",
            {si_v[2], se_v[2], tm_v[2], busy_v[2], done_v[2], 22'b0} | sig_v[2],
            32'd0);
        run(2, 1'b0, 1'b0, 1'b0);
        check_run(2, ref_loop(32, 16));

        // start during SHIFT and during DONE is ignored.
        so_const = 5'h01;
        run(0, 1'b0, 1'b1, 1'b0);
        start_v[0] = 1'b1;
        check_run(0, 32'h0000_00FF);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("done_start_ign", {31'b0, busy_v[0]}, 32'd0);

        // start held: second run one cycle after DONE.
        run(0, 1'b0, 1'b0, 1'b1);
        check_run(0, 32'h0000_00FF);
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("held_restart", {31'b0, busy_v[0]}, 32'd1);
        n = 0;
        while (busy_v[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("held_len", 32'(n), 32'd14);
        chk("held_sig", sig_v[0], 32'h0000_00FF);
        chk("held_done", {31'b0, done_v[0]}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
